// File: rtl/tcbm_host_xfer.sv
// tcbm_host_xfer: host end of the TCBM 4-phase DAV/ACK byte handshake.
// Optional per-edge ACK timeout is built when TCBM_HOST_TIMEOUT_EN is defined.
module tcbm_host_xfer #(
  parameter int unsigned SETUP_CYCLES   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic [1:0] status,
  output logic       timeout_err,
  inout  wire  [7:0] pins,
  input  logic [1:0] status_in,
  output logic       dav,
  input  logic       ack_in
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_WAIT_HI,
    S_DONE
  } state_e;

  localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYCLES - 1);

  state_e     state_q, state_d;
  logic [7:0] setup_cnt_q, setup_cnt_d;
  logic       rw_q, rw_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rdata_q, rdata_d;
  logic [1:0] status_q, status_d;
  logic       ack_m_q, ack_s_q;
  logic       to_fire;
  logic       drive_en;

  // ack_in is asynchronous; only ack_s_q may steer the FSM
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ack_m_q <= 1'b1;
      ack_s_q <= 1'b1;
    end else begin
      ack_m_q <= ack_in;
      ack_s_q <= ack_m_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      setup_cnt_q <= 8'h00;
      rw_q        <= 1'b0;
      wdata_q     <= 8'h00;
      rdata_q     <= 8'h00;
      status_q    <= 2'b00;
    end else begin
      state_q     <= state_d;
      setup_cnt_q <= setup_cnt_d;
      rw_q        <= rw_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      status_q    <= status_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    setup_cnt_d = setup_cnt_q;
    rw_d        = rw_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    status_d    = status_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          rw_d        = rw;
          wdata_d     = wdata;
          setup_cnt_d = 8'h00;
          state_d     = S_SETUP;
        end
      end
      S_SETUP: begin
        if (setup_cnt_q == SETUP_LAST) begin
          state_d = S_STROBE;
        end else begin
          setup_cnt_d = setup_cnt_q + 8'd1;
        end
      end
      S_STROBE: begin
        if (!ack_s_q) begin
          state_d = S_HOLD;
        end else if (to_fire) begin
          state_d = S_DONE;
        end
      end
      S_HOLD: begin
        if (rw_q) begin
          rdata_d  = pins;
          status_d = status_in;
        end
        state_d = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (ack_s_q || to_fire) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

`ifdef TCBM_HOST_TIMEOUT_EN
  logic [15:0] to_cnt_q, to_cnt_d;
  logic        terr_q, terr_d;
  logic        in_wait;

  assign in_wait = (state_q == S_STROBE) || (state_q == S_WAIT_HI);

  // fires only while the awaited ACK edge is still missing
  assign to_fire = (to_cnt_q == 16'(TIMEOUT_CYCLES - 1)) &&
                   (((state_q == S_STROBE) && ack_s_q) ||
                    ((state_q == S_WAIT_HI) && !ack_s_q));

  always_comb begin
    to_cnt_d = to_cnt_q;
    terr_d   = terr_q;
    if ((state_q == S_IDLE) && start) begin
      terr_d = 1'b0;
    end
    if (to_fire) begin
      terr_d = 1'b1;
    end
    if (state_d != state_q &&
        (state_d == S_STROBE || state_d == S_WAIT_HI)) begin
      to_cnt_d = 16'h0000;
    end else if (in_wait) begin
      to_cnt_d = to_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      to_cnt_q <= 16'h0000;
      terr_q   <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      terr_q   <= terr_d;
    end
  end

  assign timeout_err = terr_q;
`else
  logic unused_timeout;

  assign unused_timeout = ^16'(TIMEOUT_CYCLES);
  assign to_fire        = 1'b0;
  assign timeout_err    = 1'b0;
`endif

  assign drive_en = !rw_q &&
                    ((state_q == S_SETUP)  || (state_q == S_STROBE) ||
                     (state_q == S_HOLD)   || (state_q == S_WAIT_HI));

  assign pins   = drive_en ? wdata_q : 8'hzz;
  assign dav    = !((state_q == S_STROBE) || (state_q == S_HOLD));
  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign rdata  = rdata_q;
  assign status = status_q;

endmodule

// File: doc/tcbm_host_xfer.md
# tcbm_host_xfer

Host-side TCBM bus engine: the initiating end of the parallel handshake that the drive-side I/O ports answer. A local controller requests one byte transfer (write to drive or read from drive). The block drives the 8-bit data lines, strobes DAV, and follows the drive's ACK through a full 4-phase handshake. On reads it captures the data and the 2-bit status, then reports completion with a one-cycle pulse.

## Interface
Parameters:
- SETUP_CYCLES, 4, clocks data/direction are stable on the bus before DAV falls (1..255)
- TIMEOUT_CYCLES, 65535, clocks to wait for each ACK edge before aborting (16-bit)

Ports:
- clock  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  request a transfer; sampled only in IDLE
- rw  in  1  1 = read from drive, 0 = write to drive; latched with start
- wdata  in  8  write byte; latched with start
- busy  out  1  high from the cycle after accepted start until DONE completes
- done  out  1  one-cycle pulse when a transfer ends (normal or timeout)
- rdata  out  8  byte captured on last successful read
- status  out  2  status_in captured on last successful read
- timeout_err  out  1  last transfer aborted on timeout (sticky until next start)
- pins  inout  8  TCBM data lines
- status_in  in  2  drive status lines
- dav  out  1  data-valid strobe, active-low
- ack_in  in  1  drive acknowledge, active-low, asynchronous to clock

## Operation
- ack_in passes through a 2-FF synchronizer (ack_s). All FSM decisions use ack_s only.
- Write data is driven onto pins only in SETUP, STROBE, HOLD and WAIT_HI when rw=0. Otherwise pins are all Z.
- States:
  - IDLE: dav=1. If start=1, latch rw/wdata, clear timeout_err, go to SETUP.
  - SETUP: count SETUP_CYCLES clocks, then go to STROBE.
  - STROBE: dav=0. When ack_s=0, go to HOLD.
  - HOLD: for one cycle; if rw=1, capture rdata<=pins and status<=status_in. Set dav=1 and go to WAIT_HI.
  - WAIT_HI: dav=1. When ack_s=1, go to DONE.
  - DONE: done=1 for one cycle, bus released, then go to IDLE.
- start is ignored while busy. There is no queueing.
- rdata/status are unchanged by write transfers and by aborted transfers.
- Reset mid-transfer: dav returns to 1 and pins go Z immediately (asynchronously). No done pulse is generated.
- Reset values: busy=0, done=0, dav=1, pins=Z, rdata=8'h00, status=2'b00, timeout_err=0, FSM=IDLE, synchronizer=1.

## Timing
- start high at edge N: busy=1 and SETUP entered after edge N.
- dav falls after edge N+SETUP_CYCLES.
- ack_in low before edge M: ack_s low after edge M+1. HOLD is entered at M+2 and dav rises after M+3.
- ack_in high before edge K: DONE is entered at K+2, done pulses for one cycle, and busy drops with IDLE at K+3.
- Minimum transfer with an instantly responding drive: SETUP_CYCLES + 8 clocks from start to done.
- A new start in the cycle after done is accepted.
- A ready ACK (already 0) on entering STROBE still costs the 2 synchronizer cycles. No shortcut.

## Configuration
- Macro: TCBM_HOST_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to STROBE and to WAIT_HI, and increments each cycle in those states.
  - Reaching TIMEOUT_CYCLES sets timeout_err=1, forces dav=1, releases pins, and goes to DONE (done pulses).
  - A timeout in STROBE never reaches HOLD, so no capture occurs.
- Undefined:
  - No counter is built. STROBE and WAIT_HI wait indefinitely.
  - timeout_err is tied 0.

## Test plan
- Write: start, rw=0, wdata=8'hA5, drive answers ACK after 3 clocks -> pins=8'hA5 from SETUP to WAIT_HI, dav low until ACK seen + 3, one done pulse, pins Z afterwards, rdata unchanged.
- Read: rw=1, drive presents pins=8'h3C, status_in=2'b10, then ACK -> rdata=8'h3C, status=2'b10, bus never driven by host.
- Back-to-back: second start in the cycle after done -> accepted; start pulses while busy -> ignored, with exactly two done pulses total.
- Timeout (macro defined, TIMEOUT_CYCLES=16): ACK held high -> dav rises and done pulses with timeout_err=1 after 16 STROBE cycles; next start clears timeout_err.
- Reset mid-transfer: reset low during STROBE on a write -> dav=1 and pins Z asynchronously, busy=0, no done pulse; after release the next transfer completes normally.
- Handshake order: ACK asserted before dav falls -> FSM still passes SETUP fully; dav is never low while ack_s is high in WAIT_HI.
